hs_responder_mc: RTL and testbench

Multi-channel four-phase req/ack handshake responder. It generalises the single-channel protocol state machine to NCH requesters with configurable data width and processing latency. Arbitration between channels is round-robin, and a transfer-valid strobe marks each accepted word. An optional deassert-timeout stops a requester that never drops req from stalling the block. It sits between several request/data producers and one downstream consumer of data_out.

---
 rtl/hs_pkg.sv | 20 ++
 rtl/hs_responder_mc_rr_arbiter.sv | 43 ++++
 rtl/hs_responder_mc.sv | 170 +++++++++++++++++
 tb/tb_hs_responder_mc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared types and helpers for the multi-channel handshake responder.
//   state_t : protocol FSM state encoding (2-bit, all encodings used)
//   idx_w() : index width for an N-entry vector, never narrower than 1 bit
// -----------------------------------------------------------------------------
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    PROCESS       = 2'd1,
    SEND_ACK      = 2'd2,
    WAIT_DEASSERT = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_responder_mc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first requesting channel at or
// after (ptr_i + 1) mod N, wrapping. The pointer register lives in the parent.
//   req_i       : request vector (already masked by the parent)
//   ptr_i       : index of the most recently granted channel
//   grant_o     : one-hot grant, zero when nothing requests
//   grant_idx_o : index of the granted channel, zero when nothing requests
// -----------------------------------------------------------------------------
module rr_arbiter
  import hs_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    int  c;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    c           = 0;
    // Walk N positions starting just after the pointer; the last step lands
    // on the pointer itself so a lone requester is always served.
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!found && req_i[c]) begin
        found       = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = IW'(c);
      end
    end
  end

endmodule

// File: rtl/hs_responder_mc.sv
// -----------------------------------------------------------------------------
// hs_responder_mc
// Multi-channel four-phase req/ack responder. Channels are arbitrated
// round-robin in IDLE; the winner's data word is captured, held for PROC_CYC
// cycles, then acknowledged until the requester drops req.
//
// Optional feature macro: HS_TIMEOUT_EN
//   When defined, WAIT_DEASSERT gives up after TIMEOUT cycles of req still
//   high, raises sticky timeout_err and masks the channel as stale until its
//   req is seen low.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-channel request level
//   data_in     : channel c at [c*DATA_W +: DATA_W]
//   ack         : per-channel acknowledge (one-hot or zero)
//   ready       : idle and able to grant
//   data_out    : last captured word
//   data_valid  : one-cycle strobe with the acknowledge
//   grant_id    : channel of current/last transfer
//   timeout_err : sticky timeout flag
// -----------------------------------------------------------------------------
module hs_responder_mc
  import hs_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NCH      = 4,
  parameter  int PROC_CYC = 1,
  parameter  int TIMEOUT  = 16,
  localparam int GW       = idx_w(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*DATA_W-1:0] data_in,
  output logic [NCH-1:0]        ack,
  output logic                  ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic [GW-1:0]         grant_id,
  output logic                  timeout_err
);

  localparam int CW = idx_w(PROC_CYC);

  state_t              state_q;
  logic [CW-1:0]       pcnt_q;
  logic [GW-1:0]       ptr_q;
  logic [GW-1:0]       gid_q;
  logic [NCH-1:0]      ack_q;
  logic                ready_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;

  logic [NCH-1:0]      elig_d;
  logic [NCH-1:0]      gnt_oh_d;
  logic [GW-1:0]       gnt_idx_d;

`ifdef HS_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT);
  logic [TW-1:0]       tcnt_q;
  logic [NCH-1:0]      stale_q;
  logic                terr_q;

  assign elig_d      = req & ~stale_q;
  assign timeout_err = terr_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign elig_d         = req;
  assign timeout_err    = 1'b0;
`endif

  rr_arbiter #(.N(NCH)) u_arb (
    .req_i       (elig_d),
    .ptr_i       (ptr_q),
    .grant_o     (gnt_oh_d),
    .grant_idx_o (gnt_idx_d)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ptr_q   <= GW'(NCH - 1);   // channel 0 wins first after reset
      gid_q   <= '0;
      ack_q   <= '0;
      ready_q <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef HS_TIMEOUT_EN
      tcnt_q  <= '0;
      stale_q <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef HS_TIMEOUT_EN
      // A stale channel is forgiven once its req is seen low.
      stale_q <= stale_q & req;
`endif
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          ack_q   <= '0;
          if (|gnt_oh_d) begin
            gid_q   <= gnt_idx_d;
            ptr_q   <= gnt_idx_d;
            data_q  <= data_in[int'(gnt_idx_d)*DATA_W +: DATA_W];
            ready_q <= 1'b0;
            pcnt_q  <= '0;
            state_q <= PROCESS;
          end
        end

        PROCESS: begin
          if (pcnt_q == CW'(PROC_CYC - 1)) begin
            ack_q   <= NCH'(1) << gid_q;
            valid_q <= 1'b1;
            state_q <= SEND_ACK;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end

        SEND_ACK: begin
`ifdef HS_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
          state_q <= WAIT_DEASSERT;
        end

        WAIT_DEASSERT: begin
          if (!req[gid_q]) begin
            ack_q   <= '0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
`ifdef HS_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            ack_q          <= '0;
            ready_q        <= 1'b1;
            terr_q         <= 1'b1;
            stale_q[gid_q] <= 1'b1;
            state_q        <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`endif
        end

        default: begin
          ack_q   <= '0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign ready      = ready_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_hs_responder_mc.sv
// -----------------------------------------------------------------------------
// tb_hs_responder_mc
// Directed bench for hs_responder_mc (NCH=4, DATA_W=8, PROC_CYC=2,
// TIMEOUT=16). The timeout scenario is selected by HS_TIMEOUT_EN, matching
// the RTL build.
// -----------------------------------------------------------------------------
module tb_hs_responder_mc;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int PC  = 2;
  localparam int TO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    ack;
  logic              ready;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic [1:0]        grant_id;
  logic              timeout_err;

  logic [DW-1:0] slv [NCH] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  int n_checks = 0;
  int n_fail   = 0;

  hs_responder_mc #(
    .DATA_W   (DW),
    .NCH      (NCH),
    .PROC_CYC (PC),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .ready       (ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for any acknowledge; returns the number of edges taken.
  task automatic wait_ack(output int n);
    n = 0;
    while (ack == '0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   32'(ack),         32'h0);
    check({tag, "_ready"}, 32'(ready),       32'h1);
    check({tag, "_data"},  32'(data_out),    32'h0);
    check({tag, "_valid"}, 32'(data_valid),  32'h0);
    check({tag, "_gid"},   32'(grant_id),    32'h0);
    check({tag, "_terr"},  32'(timeout_err), 32'h0);
  endtask

  initial begin
    int n;
    int exp;
    data_in = {slv[3], slv[2], slv[1], slv[0]};
    rst     = 1'b1;
    req     = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // ---- single channel transfer ----
    req = 4'b0001;
    tick();
    check("t1_grant_ready", 32'(ready),    32'h0);
    check("t1_grant_data",  32'(data_out), 32'hA5);
    check("t1_grant_ack",   32'(ack),      32'h0);
    wait_ack(n);
    check("t1_latency", 32'(n),          32'(PC));
    check("t1_ack",     32'(ack),        32'h1);
    check("t1_valid",   32'(data_valid), 32'h1);
    check("t1_data",    32'(data_out),   32'hA5);
    tick();
    check("t1_valid_drop", 32'(data_valid), 32'h0);
    check("t1_ack_hold",   32'(ack),        32'h1);
    req = '0;
    tick();
    check("t1_ack_fall",  32'(ack),      32'h0);
    check("t1_ready",     32'(ready),    32'h1);
    check("t1_data_held", 32'(data_out), 32'hA5);

    // ---- all channels requesting: round robin 0,1,2,3,0 ----
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = k % NCH;
      wait_ack(n);
      check($sformatf("t2_lat%0d", k),   32'(n),          32'(PC + 1));
      check($sformatf("t2_gid%0d", k),   32'(grant_id),   32'(exp));
      check($sformatf("t2_ack%0d", k),   32'(ack),        32'(1 << exp));
      check($sformatf("t2_valid%0d", k), 32'(data_valid), 32'h1);
      check($sformatf("t2_data%0d", k),  32'(data_out),   32'(slv[exp]));
      tick();
      req[exp] = 1'b0;
      tick();
      check($sformatf("t2_idle%0d", k), 32'(ready), 32'h1);
      req[exp] = 1'b1;
    end
    req = '0;
    tick();

    // ---- one-cycle pulse on channel 2 ----
    req = 4'b0100;
    tick();
    req = '0;
    check("t3_gid", 32'(grant_id), 32'h2);
    wait_ack(n);
    check("t3_latency", 32'(n),        32'(PC));
    check("t3_ack_send", 32'(ack),     32'h4);
    check("t3_data",    32'(data_out), 32'h5A);
    tick();
    check("t3_ack_wait", 32'(ack), 32'h4);
    tick();
    check("t3_ack_fall", 32'(ack),   32'h0);
    check("t3_ready",    32'(ready), 32'h1);

    // ---- channel 1 never drops req, channel 3 also pending ----
    do_reset();
    req = 4'b1010;
    wait_ack(n);
    check("t4_gid_first", 32'(grant_id), 32'h1);
    check("t4_ack_first", 32'(ack),      32'h2);
`ifdef HS_TIMEOUT_EN
    n = 0;
    while (ack != '0 && n < 60) begin
      tick();
      n++;
    end
    check("t4_timeout_len", 32'(n),           32'(TO + 1));
    check("t4_terr",        32'(timeout_err), 32'h1);
    check("t4_ready",       32'(ready),       32'h1);
    wait_ack(n);
    check("t4_gid_next", 32'(grant_id), 32'h3);
    check("t4_ack_next", 32'(ack),      32'h8);
    tick();
    req[3] = 1'b0;
    tick();
    check("t4_ch3_done", 32'(ack), 32'h0);
    repeat (6) tick();
    check("t4_stale_ready", 32'(ready),    32'h1);
    check("t4_stale_ack",   32'(ack),      32'h0);
    check("t4_stale_gid",   32'(grant_id), 32'h3);
    req[1] = 1'b0;
    tick();
    req[1] = 1'b1;
    wait_ack(n);
    check("t4_regrant",    32'(grant_id),    32'h1);
    check("t4_terr_stick", 32'(timeout_err), 32'h1);
    req = '0;
    tick();
    tick();
`else
    repeat (30) tick();
    check("t4_ack_held", 32'(ack),         32'h2);
    check("t4_no_terr",  32'(timeout_err), 32'h0);
    check("t4_busy",     32'(ready),       32'h0);
    req[1] = 1'b0;
    tick();
    check("t4_ack_fall", 32'(ack), 32'h0);
    wait_ack(n);
    check("t4_gid_next", 32'(grant_id), 32'h3);
    tick();
    req = '0;
    tick();
`endif

    // ---- asynchronous reset mid-transfer ----
    do_reset();
    req = 4'b0001;
    tick();
    check("t5_in_process", 32'(ready), 32'h0);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t5_rst_process");
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0110;
    wait_ack(n);
    check("t5_gid_after", 32'(grant_id), 32'h1);
    check("t5_data_after", 32'(data_out), 32'h3C);
    tick();
    check("t5_in_wait", 32'(ack), 32'h2);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t5_rst_wait");
    @(negedge clk);
    rst = 1'b0;
    wait_ack(n);
    check("t5_gid_again", 32'(grant_id), 32'h1);
    req = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
